// File: rtl/sram_arbiter.sv
// Two-port fixed-priority arbiter in front of sram_ctrl. Port 0 normally wins, but
// after MAX_STREAK consecutive wins over a waiting port 1, port 1 gets the next slot.
module sram_arbiter #(
   parameter int AW         = 18,
   parameter int DW         = 16,
   parameter int MAX_STREAK = 4
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            p0_read,
   input  logic            p0_write,
   input  logic [AW-1:0]   p0_address,
   input  logic [DW-1:0]   p0_wdata,
   input  logic [DW/8-1:0] p0_strobe,
   output logic            p0_ready,
   output logic            p0_rvalid,
   output logic [DW-1:0]   p0_rdata,
   input  logic            p1_read,
   input  logic            p1_write,
   input  logic [AW-1:0]   p1_address,
   input  logic [DW-1:0]   p1_wdata,
   input  logic [DW/8-1:0] p1_strobe,
   output logic            p1_ready,
   output logic            p1_rvalid,
   output logic [DW-1:0]   p1_rdata,
   output logic            m_read,
   output logic            m_write,
   output logic [AW-1:0]   m_address,
   output logic [DW-1:0]   m_wdata,
   output logic [DW/8-1:0] m_strobe,
   input  logic [DW-1:0]   m_rdata
);

   localparam int SW = $clog2(MAX_STREAK + 1);

   logic          req0, req1, gnt0, gnt1, at_limit, rd_acc;
   logic [SW-1:0] streak_q, streak_d;
   logic [2:1]    vld_q, port_q;
   logic [DW-1:0] rdata_q;

   assign req0     = p0_read | p0_write;
   assign req1     = p1_read | p1_write;
   assign at_limit = (streak_q == SW'(MAX_STREAK));
   assign gnt0     = ~reset & req0 & (~req1 | ~at_limit);
   assign gnt1     = ~reset & req1 & (~req0 | at_limit);

   assign p0_ready = gnt0;
   assign p1_ready = gnt1;

   // write wins when read and write are both asserted
   assign rd_acc    = (gnt0 & p0_read & ~p0_write) | (gnt1 & p1_read & ~p1_write);
   assign m_read    = rd_acc;
   assign m_write   = (gnt0 & p0_write) | (gnt1 & p1_write);
   assign m_address = gnt1 ? p1_address : p0_address;
   assign m_wdata   = gnt1 ? p1_wdata   : p0_wdata;
   assign m_strobe  = gnt1 ? p1_strobe  : p0_strobe;

   always_comb begin
      streak_d = streak_q;
      if (!req1 || gnt1)
         streak_d = '0;
      else if (gnt0 && !at_limit)
         streak_d = streak_q + SW'(1);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         streak_q <= '0;
         vld_q    <= '0;
         port_q   <= '0;
         rdata_q  <= '0;
      end else begin
         streak_q <= streak_d;
         vld_q    <= {vld_q[1], rd_acc};
         port_q   <= {port_q[1], gnt1};
         // sram_ctrl presents read data one cycle after accept
         if (vld_q[1])
            rdata_q <= m_rdata;
      end
   end

   // gating with reset also suppresses responses that would land in a reset cycle
   assign p0_rvalid = vld_q[2] & ~port_q[2] & ~reset;
   assign p1_rvalid = vld_q[2] &  port_q[2] & ~reset;
   assign p0_rdata  = rdata_q;
   assign p1_rdata  = rdata_q;

endmodule

// File: tb/tb_sram_arbiter.sv
// Bench for sram_arbiter: behavioural SRAM behind the arbiter, plus a transaction-level
// reference (grant rule, shadow memory, queue of due read responses).
module tb_sram_arbiter;
   localparam int AW = 18;
   localparam int DW = 16;
   localparam int MS = 4;

   logic          clk = 1'b0;
   logic          reset;
   logic          p0_read, p0_write, p1_read, p1_write;
   logic [AW-1:0] p0_address, p1_address;
   logic [DW-1:0] p0_wdata, p1_wdata;
   logic [1:0]    p0_strobe, p1_strobe;
   logic          p0_ready, p0_rvalid, p1_ready, p1_rvalid;
   logic [DW-1:0] p0_rdata, p1_rdata;
   logic          m_read, m_write;
   logic [AW-1:0] m_address;
   logic [DW-1:0] m_wdata, m_rdata;
   logic [1:0]    m_strobe;

   always #5 clk = ~clk;

   sram_arbiter #(.AW(AW), .DW(DW), .MAX_STREAK(MS)) dut (
      .clk(clk), .reset(reset),
      .p0_read(p0_read), .p0_write(p0_write), .p0_address(p0_address),
      .p0_wdata(p0_wdata), .p0_strobe(p0_strobe), .p0_ready(p0_ready),
      .p0_rvalid(p0_rvalid), .p0_rdata(p0_rdata),
      .p1_read(p1_read), .p1_write(p1_write), .p1_address(p1_address),
      .p1_wdata(p1_wdata), .p1_strobe(p1_strobe), .p1_ready(p1_ready),
      .p1_rvalid(p1_rvalid), .p1_rdata(p1_rdata),
      .m_read(m_read), .m_write(m_write), .m_address(m_address),
      .m_wdata(m_wdata), .m_strobe(m_strobe), .m_rdata(m_rdata)
   );

   function automatic logic [15:0] merge(logic [15:0] o, logic [15:0] d, logic [1:0] s);
      return {s[1] ? d[15:8] : o[15:8], s[0] ? d[7:0] : o[7:0]};
   endfunction

   // SRAM as seen through sram_ctrl: read data appears the cycle after the access
   logic [15:0] sram [1024] = '{default: 16'hC3C3};
   logic [15:0] rd_q;
   assign m_rdata = rd_q;
   always @(posedge clk) begin
      if (m_write) sram[m_address[9:0]] <= merge(sram[m_address[9:0]], m_wdata, m_strobe);
      if (m_read)  rd_q <= sram[m_address[9:0]];
   end

   // reference state
   typedef struct { int due; bit port; logic [15:0] data; } rsp_t;
   rsp_t        q[$];
   logic [15:0] ref_mem [1024] = '{default: 16'hC3C3};
   int          cyc = 0;
   int          p1_passed = 0;   // times p1 lost to p0 in a row while asking
   bit          last_g0, last_g1;
   int          npass = 0, ntot = 0;

   task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
      ntot++;
      assert (obs === exp) npass++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   task automatic set0(logic r, logic w, logic [AW-1:0] a, logic [15:0] d, logic [1:0] s);
      p0_read = r; p0_write = w; p0_address = a; p0_wdata = d; p0_strobe = s;
   endtask
   task automatic set1(logic r, logic w, logic [AW-1:0] a, logic [15:0] d, logic [1:0] s);
      p1_read = r; p1_write = w; p1_address = a; p1_wdata = d; p1_strobe = s;
   endtask

   // One clock: check outputs against the reference, then advance it.
   task automatic step();
      logic r0, r1, g0, g1, er, ew, e0v, e1v;
      logic [AW-1:0] ea;
      logic [15:0]   ed, edat;
      logic [1:0]    es;
      #1;
      r0 = p0_read | p0_write;
      r1 = p1_read | p1_write;
      if (reset) begin
         q.delete();
         g0 = 1'b0; g1 = 1'b0;
      end else if (r0 && r1) begin
         g1 = (p1_passed >= MS);
         g0 = !g1;
      end else begin
         g0 = r0; g1 = r1;
      end
      ew = (g0 && p0_write) || (g1 && p1_write);
      er = (g0 && p0_read && !p0_write) || (g1 && p1_read && !p1_write);
      ea = g1 ? p1_address : p0_address;
      ed = g1 ? p1_wdata : p0_wdata;
      es = g1 ? p1_strobe : p0_strobe;
      e0v = 1'b0; e1v = 1'b0; edat = '0;
      if (q.size() > 0 && q[0].due == cyc) begin
         if (q[0].port) e1v = 1'b1; else e0v = 1'b1;
         edat = q[0].data;
         void'(q.pop_front());
      end
      chk("p0_ready", p0_ready, g0);
      chk("p1_ready", p1_ready, g1);
      chk("m_read", m_read, er);
      chk("m_write", m_write, ew);
      chk("m_address", m_address, ea);
      chk("m_wdata", m_wdata, ed);
      chk("m_strobe", m_strobe, es);
      chk("p0_rvalid", p0_rvalid, e0v);
      chk("p1_rvalid", p1_rvalid, e1v);
      if (e0v) chk("p0_rdata", p0_rdata, edat);
      if (e1v) chk("p1_rdata", p1_rdata, edat);
      if (reset || !r1 || g1) p1_passed = 0;
      else if (g0) p1_passed++;
      if (er) q.push_back('{cyc + 2, g1, ref_mem[ea[9:0]]});
      if (ew) ref_mem[ea[9:0]] = merge(ref_mem[ea[9:0]], ed, es);
      last_g0 = g0; last_g1 = g1;
      cyc++;
      @(negedge clk);
   endtask

   task automatic idle(int n);
      set0(0, 0, '0, '0, '0);
      set1(0, 0, '0, '0, '0);
      for (int i = 0; i < n; i++) step();
   endtask

   initial begin
      bit b0 = 0, b1 = 0;
      int kind;
      @(negedge clk);
      // reset with requests pending: nothing may be granted
      reset = 1'b1;
      set0(1, 0, 18'h00005, 16'h0, 2'b11);
      set1(0, 1, 18'h00006, 16'h1234, 2'b11);
      step(); step();
      reset = 1'b0;
      idle(1);
      chk("p0_rdata_rst", p0_rdata, 16'h0);
      chk("p1_rdata_rst", p1_rdata, 16'h0);

      // p1 write then read back
      set1(0, 1, 18'h00010, 16'hBEEF, 2'b11); step();
      set1(1, 0, 18'h00010, 16'h0, 2'b11);    step();
      idle(3);

      // preload and interleaved back-to-back reads
      set0(0, 1, 18'h00100, 16'h1111, 2'b11); step();
      set0(0, 1, 18'h00200, 16'h2222, 2'b11); step();
      set0(0, 1, 18'h00101, 16'h3333, 2'b11); step();
      set0(1, 0, 18'h00100, 16'h0, 2'b11); set1(0, 0, '0, '0, '0); step();
      set0(0, 0, '0, '0, '0); set1(1, 0, 18'h00200, 16'h0, 2'b11); step();
      set0(1, 0, 18'h00101, 16'h0, 2'b11); set1(0, 0, '0, '0, '0); step();
      idle(3);

      // read+write together is a write
      set1(1, 1, 18'h00020, 16'h1234, 2'b11); step();
      set1(1, 0, 18'h00020, 16'h0, 2'b11);    step();
      idle(3);

      // byte strobe merge
      set0(0, 1, 18'h00030, 16'hAAAA, 2'b11); step();
      set0(0, 1, 18'h00030, 16'h55FF, 2'b01); step();
      set0(1, 0, 18'h00030, 16'h0, 2'b11);    step();
      idle(1);
      chk("strobe_merge", p0_rdata, 16'hAAFF);
      idle(2);

      // both ports reading continuously: p1 wins every fifth slot
      set0(1, 0, 18'h00100, 16'h0, 2'b11);
      set1(1, 0, 18'h00200, 16'h0, 2'b11);
      for (int i = 0; i < 15; i++) step();
      idle(3);

      // streak reaches the limit exactly as p1 drops: p0 keeps winning, streak restarts
      set0(1, 0, 18'h00101, 16'h0, 2'b11);
      set1(1, 0, 18'h00200, 16'h0, 2'b11);
      for (int i = 0; i < 4; i++) step();
      set1(0, 0, '0, '0, '0); step();
      set1(1, 0, 18'h00200, 16'h0, 2'b11); step(); step();
      idle(3);

      // reset right after a read accept
      set0(1, 0, 18'h00100, 16'h0, 2'b11); step();
      set0(0, 0, '0, '0, '0); reset = 1'b1; step();
      reset = 1'b0; step();
      chk("p0_rdata_midrst", p0_rdata, 16'h0);
      step(); step();
      set0(1, 0, 18'h00101, 16'h0, 2'b11); step();
      idle(3);

      // random traffic; each requester holds its request until granted
      for (int k = 0; k < 400; k++) begin
         reset = ($urandom_range(63) == 0);
         if (!b0 && $urandom_range(1) == 1) begin
            kind = $urandom_range(2);
            set0(kind != 1, kind != 0, 18'($urandom_range(31)), 16'($urandom), 2'($urandom));
            b0 = 1;
         end else if (!b0) set0(0, 0, '0, '0, '0);
         if (!b1 && $urandom_range(1) == 1) begin
            kind = $urandom_range(2);
            set1(kind != 1, kind != 0, 18'($urandom_range(31)), 16'($urandom), 2'($urandom));
            b1 = 1;
         end else if (!b1) set1(0, 0, '0, '0, '0);
         step();
         if (last_g0) b0 = 0;
         if (last_g1) b1 = 0;
      end
      reset = 1'b0;
      idle(3);

      $display("%0d/%0d checks passed", npass, ntot);
      $finish;
   end
endmodule

// File: doc/sram_arbiter.md
# sram_arbiter

Two-port arbiter that shares the single `sram_ctrl` user bus between two requesters. Port 0 is the latency-critical requester (screen/VGA fetch) and port 1 is the Hack CPU data port. The block sits directly upstream of `sram_ctrl`. It grants at most one access per cycle using fixed priority with a starvation guard, and routes registered read data back to the requester that issued the read.

## Interface
Parameters:
- `AW`, 18, word address width (matches `sram_ctrl`)
- `DW`, 16, data width; fixed to 16
- `MAX_STREAK`, 4, maximum consecutive port-0 grants while port 1 is waiting; legal range 1..15

Ports:
- `clk`  in  1  single clock
- `reset`  in  1  synchronous, active-high reset
- `p0_read`, `p1_read`  in  1  read request, held until `pN_ready`
- `p0_write`, `p1_write`  in  1  write request, held until `pN_ready`
- `p0_address`, `p1_address`  in  AW  word address
- `p0_wdata`, `p1_wdata`  in  DW  write data
- `p0_strobe`, `p1_strobe`  in  DW/8  byte enables
- `p0_ready`, `p1_ready`  out  1  request accepted this cycle (combinational)
- `p0_rvalid`, `p1_rvalid`  out  1  read data valid, one-cycle pulse per accepted read
- `p0_rdata`, `p1_rdata`  out  DW  read data; valid only while `pN_rvalid` is high
- `m_read`, `m_write`  out  1  to `sram_ctrl` `read`/`write`
- `m_address`  out  AW  to `sram_ctrl` `address`
- `m_wdata`  out  DW  to `sram_ctrl` `wdata`
- `m_strobe`  out  DW/8  to `sram_ctrl` `strobe`
- `m_rdata`  in  DW  from `sram_ctrl` `rdata`

## Operation
- Request from port N: `reqN = pN_read | pN_write`.
  - If both `pN_read` and `pN_write` are high, the request is a write and the read is ignored. No `rvalid` is produced for it.
- Grant, evaluated combinationally each cycle, no grant while `reset` is high:
  - Only p0 requesting: grant p0.
  - Only p1 requesting: grant p1.
  - Both requesting and `streak < MAX_STREAK`: grant p0.
  - Both requesting and `streak == MAX_STREAK`: grant p1.
- Streak counter (`$clog2(MAX_STREAK+1)` bits, reset 0):
  - Increments on a p0 grant while `req1` is high.
  - Clears on any p1 grant, or in any cycle where `req1` is low.
  - Never exceeds `MAX_STREAK`.
- Downstream mux:
  - `m_*` carry the granted port's fields.
  - `m_read`/`m_write` are 0 when nothing is granted.
  - `m_address`/`m_wdata`/`m_strobe` carry p0's fields when idle.
- `pN_ready` equals the grant to port N. A request whose `pN_ready` is low is not issued; the requester holds it unchanged.
- Read return tracking:
  - A two-stage tag pipeline records `{valid, port}` for each accepted read.
  - In the stage-1 cycle, `m_rdata` (valid during that cycle per `sram_ctrl`) is captured into a data register.
  - In the stage-2 cycle, `rvalid` is asserted on the tagged port.
- `p0_rdata` and `p1_rdata` both drive the same captured data register. Only `rvalid` is steered per port.
- Writes produce no response; `pN_ready` is the completion.

## Timing
- Throughput: one access per cycle, back-to-back, with no turnaround bubble between reads and writes.
- Read latency: read accepted in cycle N → `sram_ctrl` registers it at the end of N → `m_rdata` valid in N+1, captured at the end of N+1 → `pN_rvalid` = 1 with data in N+2.
- Pipelined reads: accepts in N, N+1, N+2 give `rvalid` in N+2, N+3, N+4, each on the correct port, even when ports interleave.
- Write accepted in cycle N: `sram_ctrl` drives the SRAM in N+1.
- Reset values:
  - `pN_ready` = 0, `m_read` = 0, `m_write` = 0 while `reset` is high.
  - `pN_rvalid` = 0, `pN_rdata` = 0, `streak` = 0, tag pipeline cleared.
- Reset mid-operation: reads accepted before or during a reset cycle produce no `rvalid`. The first grant is possible in the first cycle with `reset` low.
- Simultaneous events:
  - A new accept and an old `rvalid` in the same cycle are independent.
  - If the streak threshold is hit in the same cycle p1 drops its request, p0 is granted and the streak clears.

## Test plan
- Single p1 write `addr=0x00010`, `wdata=0xBEEF`, `strobe=2'b11`, then p1 read of the same address → `p1_ready` in the request cycle; `p1_rvalid`=1 with `p1_rdata=0xBEEF` exactly 2 cycles after read accept; `p0_rvalid` stays 0.
- p0 and p1 both read continuously, `MAX_STREAK=4` → grant pattern p0,p0,p0,p0,p1 repeating; p1 is never starved more than 4 cycles; every `rvalid` appears on its issuing port with the right data.
- Interleaved back-to-back reads p0@0x100, p1@0x200, p0@0x101 preloaded with 0x1111/0x2222/0x3333 → `rvalid` on p0, p1, p0 in three consecutive cycles carrying those values.
- p1 asserts `read` and `write` together, `wdata=0x1234` → treated as a write; SRAM word updated; no `p1_rvalid`.
- Byte strobe: write 0xAAAA, then 0x55FF with `strobe=2'b01`, then read → 0xAAFF.
- p0 read accepted, then `reset` asserted on the next cycle for 1 cycle → no `rvalid` on either port; all outputs at reset values; normal operation resumes after reset deasserts.
